// File: rtl/risc_v_mmio_timer.sv
// risc_v_mmio_timer: prescaled 32-bit MMIO timer with compare/overflow status.
// Define MMIO_TIMER_IRQ_EN to add CTRL.IRQ_EN and the timer_irq output.
module risc_v_mmio_timer #(
  parameter int unsigned ADDRESS_32_W   = 32,
  parameter int unsigned DATA_32_W      = 32,
  parameter int unsigned PRESCALE_W     = 16,
  parameter logic [31:0] TIMER_REG_SPAN = 32'h14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    data_mmio_wr_addr_val,
  input  logic [ADDRESS_32_W-1:0] data_mmio_wr_addr,
  input  logic [DATA_32_W-1:0]    mmio_wr_data,
  input  logic                    data_mmio_rd_addr_val,
  input  logic [ADDRESS_32_W-1:0] data_mmio_rd_addr,
  output logic [DATA_32_W-1:0]    mmio_rd_data,
  output logic                    mmio_access_error
`ifdef MMIO_TIMER_IRQ_EN
  ,
  output logic                    timer_irq
`endif
);

  localparam logic [ADDRESS_32_W-1:0] OFF_CTRL =
    ADDRESS_32_W'(32'h00);
  localparam logic [ADDRESS_32_W-1:0] OFF_PRE =
    ADDRESS_32_W'(32'h04);
  localparam logic [ADDRESS_32_W-1:0] OFF_CMP =
    ADDRESS_32_W'(32'h08);
  localparam logic [ADDRESS_32_W-1:0] OFF_CNT =
    ADDRESS_32_W'(32'h0C);
  localparam logic [ADDRESS_32_W-1:0] OFF_STS =
    ADDRESS_32_W'(32'h10);
  localparam logic [ADDRESS_32_W-1:0] SPAN_A =
    ADDRESS_32_W'(TIMER_REG_SPAN);

  logic                  en_q, en_d;
  logic                  ar_q, ar_d;
  logic                  ie_rd;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [DATA_32_W-1:0]  compare_q, compare_d;
  logic [DATA_32_W-1:0]  count_q, count_d;
  logic                  match_q, match_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;

`ifdef MMIO_TIMER_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q, irq_d;
`endif

  logic wr_ok, rd_ok;
  logic wr_ctrl, wr_pre, wr_cmp, wr_cnt, wr_sts;
  logic tick, hit_cmp, hit_max;
  logic match_set, ovf_set;

  // Mapped means inside the window and word aligned.
  function automatic logic addr_ok(
    input logic [ADDRESS_32_W-1:0] a
  );
    return (a < SPAN_A) && (a[1:0] == 2'b00);
  endfunction

  // Qualify strobes and decode the write target.
  always_comb begin
    wr_ok   = data_mmio_wr_addr_val &&
              addr_ok(data_mmio_wr_addr);
    rd_ok   = data_mmio_rd_addr_val &&
              addr_ok(data_mmio_rd_addr);
    wr_ctrl = wr_ok && (data_mmio_wr_addr == OFF_CTRL);
    wr_pre  = wr_ok && (data_mmio_wr_addr == OFF_PRE);
    wr_cmp  = wr_ok && (data_mmio_wr_addr == OFF_CMP);
    wr_cnt  = wr_ok && (data_mmio_wr_addr == OFF_CNT);
    wr_sts  = wr_ok && (data_mmio_wr_addr == OFF_STS);
    err_d   = (data_mmio_wr_addr_val &&
               !addr_ok(data_mmio_wr_addr)) ||
              (data_mmio_rd_addr_val &&
               !addr_ok(data_mmio_rd_addr));
  end

  // Tick handling first, then software writes override it.
  always_comb begin
    en_d       = en_q;
    ar_d       = ar_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_q;
    match_set  = 1'b0;
    ovf_set    = 1'b0;
    tick       = en_q && (pre_cnt_q == prescale_q);
    hit_cmp    = (count_q == compare_q);
    hit_max    = &count_q;

    if (!en_q || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    end

    // A coincident COUNT write discards the whole tick.
    if (tick && !wr_cnt) begin
      priority case (1'b1)
        hit_cmp: begin
          match_set = 1'b1;
          if (ar_q) begin
            count_d = '0;
          end else begin
            en_d = 1'b0;
          end
        end
        hit_max: begin
          count_d = '0;
          ovf_set = 1'b1;
        end
        default: begin
          count_d = count_q + DATA_32_W'(1);
        end
      endcase
    end

    if (wr_ctrl) begin
      en_d      = mmio_wr_data[0];
      ar_d      = mmio_wr_data[1];
      pre_cnt_d = '0;
    end
    if (wr_pre) begin
      prescale_d = mmio_wr_data[PRESCALE_W-1:0];
      pre_cnt_d  = '0;
    end
    if (wr_cmp) begin
      compare_d = mmio_wr_data;
    end
    if (wr_cnt) begin
      count_d = mmio_wr_data;
    end

    // Hardware set beats a coincident write-1-to-clear.
    match_d = match_q;
    ovf_d   = ovf_q;
    if (wr_sts) begin
      match_d = match_q & ~mmio_wr_data[0];
      ovf_d   = ovf_q & ~mmio_wr_data[1];
    end
    match_d = match_d | match_set;
    ovf_d   = ovf_d | ovf_set;
  end

`ifdef MMIO_TIMER_IRQ_EN
  // IRQ enable storage and registered level interrupt.
  always_comb begin
    ie_d  = wr_ctrl ? mmio_wr_data[2] : ie_q;
    irq_d = ie_q & match_q;
    ie_rd = ie_q;
  end

  // Interrupt-side state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign timer_irq = irq_q;
`else
  assign ie_rd = 1'b0;
`endif

  // Combinational read return, pre-write state.
  always_comb begin
    mmio_rd_data = '0;
    if (rd_ok) begin
      unique case (1'b1)
        data_mmio_rd_addr == OFF_CTRL:
          mmio_rd_data = DATA_32_W'({ie_rd, ar_q, en_q});
        data_mmio_rd_addr == OFF_PRE:
          mmio_rd_data = DATA_32_W'(prescale_q);
        data_mmio_rd_addr == OFF_CMP:
          mmio_rd_data = compare_q;
        data_mmio_rd_addr == OFF_CNT:
          mmio_rd_data = count_q;
        data_mmio_rd_addr == OFF_STS:
          mmio_rd_data = DATA_32_W'({ovf_q, match_q});
        default:
          mmio_rd_data = '0;
      endcase
    end
  end

  // Timer register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      ar_q       <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      compare_q  <= '0;
      count_q    <= '0;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      ar_q       <= ar_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign mmio_access_error = err_q;

endmodule

// File: doc/risc_v_mmio_timer.md
# risc_v_mmio_timer

Memory-mapped timer peripheral in the MMIO region (0xffff0000 base), directly downstream of the memory-bus address decode. It consumes the decoded MMIO write/read valids and window-relative addresses. It provides:
- a prescaled 32-bit up-counter with compare match, optional auto-reload and overflow status;
- a combinational read-data return to the load path;
- an optional interrupt line.

## Interface
Parameters:
- PRESCALE_W, 16, width of the prescale divider register and counter.
- TIMER_REG_SPAN, 32'h14, byte span of the register window; offsets at or above it are unmapped.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- data_mmio_wr_addr_val  in  1  write strobe for the MMIO window
- data_mmio_wr_addr  in  ADDRESS_32_W  byte offset in the MMIO window
- mmio_wr_data  in  DATA_32_W  store data
- data_mmio_rd_addr_val  in  1  read strobe for the MMIO window
- data_mmio_rd_addr  in  ADDRESS_32_W  byte offset in the MMIO window
- mmio_rd_data  out  DATA_32_W  read data, combinational
- mmio_access_error  out  1  registered one-cycle pulse on an unmapped or misaligned access
- timer_irq  out  1  level interrupt (MMIO_TIMER_IRQ_EN only)

## Operation
Register map (word-aligned byte offsets):
- 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read 0.
- 0x04 PRESCALE: [PRESCALE_W-1:0]. Counter ticks once every PRESCALE+1 clk cycles.
- 0x08 COMPARE: 32-bit compare value.
- 0x0C COUNT: 32-bit counter, read/write.
- 0x10 STATUS: bit0 MATCH, bit1 OVF. Write-1-to-clear. Other bits read 0.

Access rules:
- Offset ≥ TIMER_REG_SPAN or offset[1:0] ≠ 0 → write ignored, read returns 0, mmio_access_error pulses the next cycle.
- Only full 32-bit writes are supported; no byte enables.

Prescaler:
- Internal pre_cnt [PRESCALE_W-1:0]. While EN=1 it increments each cycle.
- When pre_cnt == PRESCALE it generates a tick and returns to 0.
- EN=0 holds pre_cnt at 0.

On each tick, evaluated in this order:
- COUNT == COMPARE → MATCH set.
  - AUTO_RELOAD=1 → COUNT := 0.
  - AUTO_RELOAD=0 → COUNT holds and EN clears (one-shot).
- Otherwise, COUNT == 32'hFFFFFFFF → COUNT := 0 and OVF set.
- Otherwise → COUNT := COUNT + 1 (modulo 2^32).

Writes:
- Writing PRESCALE or CTRL resets pre_cnt to 0.
- A write to COUNT in the same cycle as a tick: the software value wins and the tick is discarded.

Simultaneous events:
- STATUS write-1-clear in the same cycle a hardware set occurs → set wins and the flag remains 1.
- A CTRL write in the same cycle as a one-shot EN clear → software write wins.
- Reads and writes in the same cycle to the same register → the read returns the pre-write value.

## Timing
- All registers, pre_cnt and mmio_access_error reset to 0. timer_irq resets to 0.
- Write latency: a register updates on the clk edge where data_mmio_wr_addr_val is high. The new value is visible to a read the following cycle.
- Read latency: 0. mmio_rd_data is a function of data_mmio_rd_addr and the current register state.
- mmio_rd_data is 0 when data_mmio_rd_addr_val=0.
- MATCH/OVF become visible the cycle after the tick edge.
- Reset asserted mid-count: all state clears immediately (asynchronous). Counting resumes only after software sets EN.
- With PRESCALE=0, a tick occurs every cycle while EN=1. Enabling with COUNT=0 and COMPARE=N gives MATCH N+1 cycles after the EN write edge.

## Configuration
- MMIO_TIMER_IRQ_EN defined:
  - timer_irq port exists.
  - timer_irq = IRQ_EN & MATCH, registered, so it asserts the cycle after MATCH.
  - CTRL bit2 is writable.
- MMIO_TIMER_IRQ_EN undefined:
  - timer_irq port is absent.
  - CTRL bit2 is not stored and reads 0.
  - All other behaviour is unchanged.

## Test plan
- Reset/readback: after rst_n release, read offsets 0x00–0x10 → all 0. Write COMPARE=32'hDEADBEEF, read 0x08 next cycle → 32'hDEADBEEF.
- One-shot: PRESCALE=0, COMPARE=5, CTRL=1 → MATCH=1 and EN=0 six cycles after the CTRL write edge; COUNT holds 5. Write STATUS=1 → MATCH=0.
- Auto-reload with prescale: PRESCALE=3, COMPARE=2, CTRL=3 → MATCH every 12 cycles; COUNT sequence 0,1,2,0 with 4 cycles per value.
- Overflow and collisions:
  - COUNT=32'hFFFFFFFE, COMPARE=0x10, CTRL=1, PRESCALE=0 → OVF=1 two cycles after enable, COUNT=0.
  - A COUNT write coincident with a tick → the written value is retained.
  - A STATUS W1C coincident with a match → MATCH stays 1.
- Errors: write to offset 0x14 and read at offset 0x06 → each produces a one-cycle mmio_access_error pulse; no register changes; read data 0.
- IRQ (MMIO_TIMER_IRQ_EN defined): CTRL=5, COMPARE=0 → timer_irq=1 the cycle after MATCH sets. Clearing MATCH → timer_irq=0 the cycle after clear. Asserting rst_n low mid-count → timer_irq and all registers 0 asynchronously.
